cr_cceip_nch_support_core: RTL and testbench

CR_CCEIP_NCH_SUPPORT_CORE -- requirements
Module: cr_cceip_nch_support_core

---
 rtl/cr_cceip_nch_support_core_pkg.sv | 42 ++++
 rtl/cr_cceip_nch_support_core_if.sv | 23 ++
 rtl/cr_cceip_sat_updn_cnt.sv | 26 ++
 rtl/cr_cceip_nch_support_core.sv | 159 +++++++++++++++
 tb/tb_cr_cceip_nch_support_core.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_cceip_nch_support_core_pkg.sv
// Shared stream/status types (cr_cceip_nch_support_core_pkg) and the
// support-core constants (cr_cceip_64_supportPKG).
package cr_cceip_nch_support_core_pkg;

   typedef struct packed {
      logic        tvalid;
      logic        tlast;
      logic [7:0]  tuser;
      logic [63:0] tdata;
   } axi4s_dp_bus_t;

   typedef struct packed {
      logic tready;
   } axi4s_dp_rdy_t;

   typedef struct packed {
      logic       isf_busy;
      logic       data_busy;
      logic       comp_busy;
      logic [7:0] isf_cmds;
      logic [7:0] pipe_cmds;
   } pipe_stat_t;

endpackage

package cr_cceip_64_supportPKG;

   typedef enum logic [0:0] {
      SEL_IDLE = 1'b0,
      SEL_PKT  = 1'b1
   } sel_state_e;

   localparam int CNT_ERR_PIPE = 0;
   localparam int CNT_ERR_ISF  = 1;
   localparam int CNT_ERR_CQE  = 2;

   localparam int N_CH_MIN  = 2;
   localparam int N_CH_MAX  = 8;
   localparam int CNT_W_MIN = 4;
   localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/cr_cceip_nch_support_core_if.sv
// Inbound channel streams, channel select and outbound stream of the support core.
interface cr_cceip_nch_support_core_if #(
   parameter int N_CH = 2
);
   import cr_cceip_nch_support_core_pkg::*;

   axi4s_dp_bus_t               ch_ib_in  [N_CH];
   axi4s_dp_rdy_t               ch_ib_out [N_CH];
   logic [N_CH-1:0]             ch_gate_rdy;
   logic [$clog2(N_CH)-1:0]     df_mux_sel;
   axi4s_dp_rdy_t               df_mux_ob_in;
   axi4s_dp_bus_t               df_mux_ob_out;

   modport master (
      output ch_ib_in, ch_gate_rdy, df_mux_sel, df_mux_ob_in,
      input  ch_ib_out, df_mux_ob_out
   );

   modport slave (
      input  ch_ib_in, ch_gate_rdy, df_mux_sel, df_mux_ob_in,
      output ch_ib_out, df_mux_ob_out
   );
endinterface

// File: rtl/cr_cceip_sat_updn_cnt.sv
// Saturating up/down command counter with a sticky over/underflow flag.
module cr_cceip_sat_updn_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             err
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (inc && !dec) begin
         if (cnt == '1) err <= 1'b1;
         else           cnt <= cnt + 1'b1;
      end else if (dec && !inc) begin
         if (cnt == '0) err <= 1'b1;
         else           cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/cr_cceip_nch_support_core.sv
// N-channel packet mux with command counters, idle detect and interrupt fan-out.
// Optional macro CR_CCEIP_NCH_SUPPORT_INT_STICKY_EN latches the interrupt until int_clr.
module cr_cceip_nch_support_core
   import cr_cceip_nch_support_core_pkg::*;
   import cr_cceip_64_supportPKG::*;
#(
   parameter int N_CH     = 2,
   parameter int CNT_W    = 8,
   parameter int IDLE_DLY = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   cr_cceip_nch_support_core_if.slave  dp,
   input  logic                        isf_sup_rqe_rx,
   input  logic                        isf_sup_cqe_rx,
   input  logic                        isf_sup_cqe_exit,
   input  logic                        osf_sup_cqe_exit,
   input  logic [N_CH-1:0]             int_in,
   input  logic                        int_clr,
   output logic                        cceip_int,
   output logic                        sup_osf_halt,
   output logic                        cceip_idle,
   output pipe_stat_t                  pipe_stat,
   output logic [2:0]                  cnt_err,
   output logic [$clog2(N_CH)-1:0]     mux_active_sel
);

   localparam int SEL_W = $clog2(N_CH);
   localparam logic [7:0] DLY_M1 = 8'(IDLE_DLY - 1);

   if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
      $error("N_CH out of range");
   end
   if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
      $error("CNT_W out of range");
   end

   sel_state_e       state;
   logic [SEL_W-1:0] act_sel;
   axi4s_dp_bus_t    sel_beat;
   axi4s_dp_bus_t    ob_beat;
   logic             beat_acc;
   logic             sel_legal;

   assign sel_beat = dp.ch_ib_in[act_sel];

   always_comb begin
      ob_beat        = sel_beat;
      ob_beat.tvalid = sel_beat.tvalid & dp.ch_gate_rdy[act_sel];
   end

   assign dp.df_mux_ob_out = ob_beat;
   assign beat_acc         = ob_beat.tvalid & dp.df_mux_ob_in.tready;
   assign sel_legal        = int'(dp.df_mux_sel) < N_CH;
   assign mux_active_sel   = act_sel;

   // Non-selected channels are always ready so their traffic drains.
   for (genvar i = 0; i < N_CH; i++) begin : g_ib_rdy
      assign dp.ch_ib_out[i] = (act_sel == SEL_W'(i)) ? dp.df_mux_ob_in
                                                      : axi4s_dp_rdy_t'(1'b1);
   end

   // Selection is only reloaded while idle and not opening a multi-beat packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= SEL_IDLE;
         act_sel <= '0;
      end else begin
         unique case (state)
            SEL_IDLE: begin
               if (beat_acc && !ob_beat.tlast) state   <= SEL_PKT;
               else if (sel_legal)              act_sel <= dp.df_mux_sel;
            end
            SEL_PKT: begin
               if (beat_acc && ob_beat.tlast)  state   <= SEL_IDLE;
            end
            default: state <= SEL_IDLE;
         endcase
      end
   end

   logic [CNT_W-1:0] pipe_cnt, isf_cnt, cqe_cnt;
   logic             pipe_err, isf_err, cqe_err;

   cr_cceip_sat_updn_cnt #(.CNT_W(CNT_W)) u_pipe_cnt (
      .clk (clk), .rst (rst), .inc (isf_sup_rqe_rx), .dec (osf_sup_cqe_exit),
      .cnt (pipe_cnt), .err (pipe_err)
   );

   cr_cceip_sat_updn_cnt #(.CNT_W(CNT_W)) u_isf_cnt (
      .clk (clk), .rst (rst), .inc (isf_sup_rqe_rx), .dec (isf_sup_cqe_exit),
      .cnt (isf_cnt), .err (isf_err)
   );

   cr_cceip_sat_updn_cnt #(.CNT_W(CNT_W)) u_cqe_cnt (
      .clk (clk), .rst (rst), .inc (isf_sup_cqe_rx), .dec (osf_sup_cqe_exit),
      .cnt (cqe_cnt), .err (cqe_err)
   );

   always_comb begin
      cnt_err               = '0;
      cnt_err[CNT_ERR_PIPE] = pipe_err;
      cnt_err[CNT_ERR_ISF]  = isf_err;
      cnt_err[CNT_ERR_CQE]  = cqe_err;
   end

   function automatic logic [7:0] cmds8(input logic [CNT_W-1:0] c);
      logic [31:0] w;
      w = 32'(c);
      return (w > 32'd255) ? 8'hFF : w[7:0];
   endfunction

   always_comb begin
      pipe_stat           = '0;
      pipe_stat.isf_busy  = (isf_cnt  != '0);
      pipe_stat.data_busy = (pipe_cnt != '0);
      pipe_stat.comp_busy = (cqe_cnt  != '0);
      pipe_stat.isf_cmds  = cmds8(isf_cnt);
      pipe_stat.pipe_cmds = cmds8(pipe_cnt);
   end

   logic       idle_cond;
   logic [7:0] idle_cnt;

   assign idle_cond = (pipe_cnt == '0) && (state == SEL_IDLE);

   // idle_cnt counts earlier qualifying cycles and parks at IDLE_DLY-1.
   always_ff @(posedge clk) begin
      if (rst || !idle_cond) begin
         idle_cnt   <= '0;
         cceip_idle <= 1'b0;
      end else begin
         if (idle_cnt != DLY_M1) idle_cnt <= idle_cnt + 1'b1;
         cceip_idle <= (idle_cnt == DLY_M1);
      end
   end

   logic int_q;

`ifdef CR_CCEIP_NCH_SUPPORT_INT_STICKY_EN
   always_ff @(posedge clk) begin
      if (rst)          int_q <= 1'b0;
      else if (|int_in) int_q <= 1'b1;
      else if (int_clr) int_q <= 1'b0;
   end
`else
   logic unused_int_clr;
   assign unused_int_clr = int_clr;

   always_ff @(posedge clk) begin
      if (rst) int_q <= 1'b0;
      else     int_q <= |int_in;
   end
`endif

   assign cceip_int    = int_q;
   assign sup_osf_halt = int_q;

endmodule

// File: tb/tb_cr_cceip_nch_support_core.sv
// Self-checking bench: per-cycle behavioural model plus directed literal checks.
module tb_cr_cceip_nch_support_core;
   import cr_cceip_nch_support_core_pkg::*;
   import cr_cceip_64_supportPKG::*;

   localparam int N_CH     = 4;
   localparam int CNT_W    = 4;
   localparam int IDLE_DLY = 4;
   localparam int CMAX     = (1 << CNT_W) - 1;
`ifdef CR_CCEIP_NCH_SUPPORT_INT_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            isf_sup_rqe_rx, isf_sup_cqe_rx, isf_sup_cqe_exit, osf_sup_cqe_exit;
   logic [N_CH-1:0] int_in;
   logic            int_clr;
   logic            cceip_int, sup_osf_halt, cceip_idle;
   pipe_stat_t      pipe_stat;
   logic [2:0]      cnt_err;
   logic [1:0]      mux_active_sel;

   cr_cceip_nch_support_core_if #(.N_CH(N_CH)) bus ();

   cr_cceip_nch_support_core #(.N_CH(N_CH), .CNT_W(CNT_W), .IDLE_DLY(IDLE_DLY)) dut (
      .clk              (clk),
      .rst              (rst),
      .dp               (bus),
      .isf_sup_rqe_rx   (isf_sup_rqe_rx),
      .isf_sup_cqe_rx   (isf_sup_cqe_rx),
      .isf_sup_cqe_exit (isf_sup_cqe_exit),
      .osf_sup_cqe_exit (osf_sup_cqe_exit),
      .int_in           (int_in),
      .int_clr          (int_clr),
      .cceip_int        (cceip_int),
      .sup_osf_halt     (sup_osf_halt),
      .cceip_idle       (cceip_idle),
      .pipe_stat        (pipe_stat),
      .cnt_err          (cnt_err),
      .mux_active_sel   (mux_active_sel)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", nm, $time, act, exp);
      end
   endtask

   // Model: packet-in-progress flag, chosen channel, clamped counts, run of idle cycles.
   bit            m_valid = 1'b0;
   bit            m_pkt;
   int            m_sel;
   int            m_pipe, m_isf, m_cqe;
   bit [2:0]      m_err;
   int            m_run;
   bit            m_idle;
   bit            m_int;
   axi4s_dp_bus_t eb;
   pipe_stat_t    eps;

   function automatic int clamp_step(input int c, input bit up, input bit dn);
      if (up && !dn) return (c == CMAX) ? c : c + 1;
      if (dn && !up) return (c == 0) ? c : c - 1;
      return c;
   endfunction

   function automatic bit clamp_fault(input int c, input bit up, input bit dn);
      return (up && !dn && c == CMAX) || (dn && !up && c == 0);
   endfunction

   task automatic model_cycle();
      eb        = bus.ch_ib_in[m_sel];
      eb.tvalid = eb.tvalid & bus.ch_gate_rdy[m_sel];
      if (m_valid) begin
         chk("df_mux_ob_out", bus.df_mux_ob_out, eb);
         for (int unsigned i = 0; i < N_CH; i++)
            chk("ch_ib_out.tready", bus.ch_ib_out[i].tready,
                (int'(i) == m_sel) ? bus.df_mux_ob_in.tready : 1'b1);
         chk("mux_active_sel", mux_active_sel, m_sel);
         eps.isf_busy  = (m_isf  != 0);
         eps.data_busy = (m_pipe != 0);
         eps.comp_busy = (m_cqe  != 0);
         eps.isf_cmds  = (m_isf  > 255) ? 8'hFF : 8'(m_isf);
         eps.pipe_cmds = (m_pipe > 255) ? 8'hFF : 8'(m_pipe);
         chk("pipe_stat", pipe_stat, eps);
         chk("cnt_err", cnt_err, m_err);
         chk("cceip_idle", cceip_idle, m_idle);
         chk("cceip_int", cceip_int, m_int);
         chk("sup_osf_halt", sup_osf_halt, m_int);
      end
      if (rst) begin
         m_valid = 1'b1; m_pkt = 1'b0; m_sel = 0;
         m_pipe = 0; m_isf = 0; m_cqe = 0; m_err = '0;
         m_run = 0; m_idle = 1'b0; m_int = 1'b0;
      end else begin
         if (m_pipe == 0 && !m_pkt) m_run = (m_run < 1000) ? m_run + 1 : m_run;
         else                       m_run = 0;
         m_idle = (m_run >= IDLE_DLY);
         if (!m_pkt) begin
            if (eb.tvalid && bus.df_mux_ob_in.tready && !eb.tlast) m_pkt = 1'b1;
            else if (int'(bus.df_mux_sel) < N_CH)                  m_sel = int'(bus.df_mux_sel);
         end else if (eb.tvalid && bus.df_mux_ob_in.tready && eb.tlast) begin
            m_pkt = 1'b0;
         end
         m_err[0] |= clamp_fault(m_pipe, isf_sup_rqe_rx, osf_sup_cqe_exit);
         m_err[1] |= clamp_fault(m_isf,  isf_sup_rqe_rx, isf_sup_cqe_exit);
         m_err[2] |= clamp_fault(m_cqe,  isf_sup_cqe_rx, osf_sup_cqe_exit);
         m_pipe = clamp_step(m_pipe, isf_sup_rqe_rx, osf_sup_cqe_exit);
         m_isf  = clamp_step(m_isf,  isf_sup_rqe_rx, isf_sup_cqe_exit);
         m_cqe  = clamp_step(m_cqe,  isf_sup_cqe_rx, osf_sup_cqe_exit);
         if (STICKY) begin
            if (|int_in)      m_int = 1'b1;
            else if (int_clr) m_int = 1'b0;
         end else begin
            m_int = |int_in;
         end
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic v, input logic l, input logic [63:0] d);
      bus.ch_ib_in[c].tvalid = v;
      bus.ch_ib_in[c].tlast  = l;
      bus.ch_ib_in[c].tuser  = 8'(c);
      bus.ch_ib_in[c].tdata  = d;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      nxt();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {isf_sup_rqe_rx, isf_sup_cqe_rx, isf_sup_cqe_exit, osf_sup_cqe_exit} = '0;
      int_in  = '0;
      int_clr = 1'b0;
      for (int c = 0; c < N_CH; c++) set_ch(c, 1'b0, 1'b0, 64'hC0DE_0000 + 64'(c));
      bus.ch_gate_rdy         = '1;
      bus.df_mux_sel          = '0;
      bus.df_mux_ob_in.tready = 1'b1;

      fork
         forever begin
            @(negedge clk);
            model_cycle();
         end
      join_none

      nxt(); nxt();
      rst = 1'b0;
      chk("reset mux_active_sel", mux_active_sel, 0);
      chk("reset cnt_err", cnt_err, 0);
      chk("reset cceip_idle", cceip_idle, 0);
      chk("reset cceip_int", cceip_int, 0);
      chk("reset pipe_stat", pipe_stat, 0);

      // 3-beat packet on ch2, select moved to 1 mid-packet
      bus.df_mux_sel = 2'd2;
      nxt();
      chk("pkt sel loaded", mux_active_sel, 2);
      for (int c = 0; c < N_CH; c++) set_ch(c, 1'b1, 1'b0, 64'h100 + 64'(c));
      set_ch(2, 1'b1, 1'b0, 64'hA1);
      nxt();
      chk("pkt beat1 sel", mux_active_sel, 2);
      bus.df_mux_sel = 2'd1;
      set_ch(2, 1'b1, 1'b0, 64'hA2);
      #1 chk("pkt beat2 data", bus.df_mux_ob_out.tdata, 64'hA2);
      nxt();
      chk("pkt beat2 sel", mux_active_sel, 2);
      set_ch(2, 1'b1, 1'b1, 64'hA3);
      #1 chk("pkt beat3 data", bus.df_mux_ob_out.tdata, 64'hA3);
      nxt();
      for (int c = 0; c < N_CH; c++) set_ch(c, 1'b0, 1'b0, 64'h200 + 64'(c));
      chk("pkt sel after tlast", mux_active_sel, 2);
      nxt();
      chk("next pkt sel", mux_active_sel, 1);
      set_ch(1, 1'b1, 1'b1, 64'hB1);
      #1 chk("next pkt from ch1", bus.df_mux_ob_out.tdata, 64'hB1);
      nxt();
      set_ch(1, 1'b0, 1'b0, 64'h0);

      // gated channel: beat never accepted, FSM keeps following df_mux_sel
      bus.ch_gate_rdy[1] = 1'b0;
      set_ch(1, 1'b1, 1'b0, 64'hC1);
      #1 chk("gated tvalid", bus.df_mux_ob_out.tvalid, 0);
      nxt(); nxt();
      bus.df_mux_sel = 2'd3;
      nxt();
      chk("gated fsm idle", mux_active_sel, 3);
      set_ch(1, 1'b0, 1'b0, 64'h0);
      bus.ch_gate_rdy = '1;
      bus.df_mux_ob_in.tready = 1'b0;
      #1 chk("backpressure sel tready", bus.ch_ib_out[3].tready, 0);
      chk("backpressure flush tready", bus.ch_ib_out[0].tready, 1);
      nxt();
      bus.df_mux_ob_in.tready = 1'b1;

      // reset mid-packet
      set_ch(3, 1'b1, 1'b0, 64'hD1);
      nxt();
      set_ch(3, 1'b0, 1'b0, 64'h0);
      bus.df_mux_sel = 2'd1;
      nxt();
      chk("mid-pkt sel hold", mux_active_sel, 3);
      rst_pulse();
      chk("mid-pkt reset sel", mux_active_sel, 0);
      nxt();
      chk("post-reset sel reload", mux_active_sel, 1);
      set_ch(1, 1'b1, 1'b0, 64'hE1);
      nxt();
      set_ch(1, 1'b1, 1'b1, 64'hE2);
      nxt();
      set_ch(1, 1'b0, 1'b0, 64'h0);
      nxt();

      // saturation at max
      rst_pulse();
      isf_sup_rqe_rx = 1'b1;
      repeat (17) nxt();
      isf_sup_rqe_rx = 1'b0;
      chk("sat pipe_cmds", pipe_stat.pipe_cmds, 15);
      chk("sat cnt_err", cnt_err, 3'b011);
      isf_sup_rqe_rx = 1'b1; osf_sup_cqe_exit = 1'b1;
      nxt();
      isf_sup_rqe_rx = 1'b0; osf_sup_cqe_exit = 1'b0;
      chk("sat simultaneous hold", pipe_stat.pipe_cmds, 15);
      chk("sat cqe underflow", cnt_err, 3'b111);

      // underflow at zero
      rst_pulse();
      isf_sup_rqe_rx = 1'b1;
      nxt(); nxt();
      isf_sup_rqe_rx = 1'b0;
      osf_sup_cqe_exit = 1'b1;
      nxt();
      osf_sup_cqe_exit = 1'b0;
      chk("uflow pipe_cmds", pipe_stat.pipe_cmds, 1);
      chk("uflow cnt_err", cnt_err, 3'b100);
      chk("uflow data_busy", pipe_stat.data_busy, 1);
      chk("uflow comp_busy", pipe_stat.comp_busy, 0);
      isf_sup_cqe_exit = 1'b1;
      nxt(); nxt();
      isf_sup_cqe_exit = 1'b0;
      chk("isf drained", pipe_stat.isf_busy, 0);
      isf_sup_cqe_rx = 1'b1;
      nxt();
      isf_sup_cqe_rx = 1'b0;
      chk("cqe busy", pipe_stat.comp_busy, 1);

      // idle delay
      rst_pulse();
      for (int k = 1; k <= 4; k++) begin
         nxt();
         chk("idle after reset", cceip_idle, k == 4);
      end
      isf_sup_rqe_rx = 1'b1;
      nxt();
      isf_sup_rqe_rx = 1'b0;
      nxt();
      chk("idle drop", cceip_idle, 0);
      osf_sup_cqe_exit = 1'b1;
      nxt();
      osf_sup_cqe_exit = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         nxt();
         chk("idle rise", cceip_idle, k == 4);
      end
      isf_sup_rqe_rx = 1'b1;
      nxt();
      isf_sup_rqe_rx = 1'b0;
      nxt();
      osf_sup_cqe_exit = 1'b1;
      nxt();
      osf_sup_cqe_exit = 1'b0;
      nxt(); nxt();
      isf_sup_rqe_rx = 1'b1;
      nxt();
      isf_sup_rqe_rx = 1'b0;
      nxt();
      chk("idle restart", cceip_idle, 0);
      osf_sup_cqe_exit = 1'b1;
      nxt();
      osf_sup_cqe_exit = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         nxt();
         chk("idle rise after restart", cceip_idle, k == 4);
      end

      // interrupt
      int_in = 4'b0010;
      nxt();
      int_in = '0;
      chk("int set", cceip_int, 1);
      chk("halt set", sup_osf_halt, 1);
      nxt();
      chk("int after pulse", cceip_int, STICKY);
      nxt();
      chk("int held", cceip_int, STICKY);
      int_in = 4'b0010; int_clr = 1'b1;
      nxt();
      chk("int clr vs set", cceip_int, 1);
      int_in = '0;
      nxt();
      int_clr = 1'b0;
      chk("int cleared", cceip_int, 0);
      nxt(); nxt();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
